ucom_timer_array: RTL and testbench
===================================

Name: ucom_timer_array

Overview:
Parametrised successor to the single uCOM-43 STM/TTM timer. Provides NCH independent down-counting timer channels, each with its own prescaler, one-shot or auto-reload mode, a sticky TM flag and a maskable interrupt request. Sits beside the 4-bit core on the CPU clock-enable. Driven by port-mapped writes, polled through TM flags, and ORed into the core's interrupt input.

Parameters:
NCH, 4, number of timer channels (1..8)
CNT_W, 6, counter width in bits
PRE_DIV, 64, prescaler period in tick_en pulses (2..256)
CH_W, 2, channel select width, equal to clog2(NCH) with a minimum of 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick_en  in  1  clock enable; all counting advances only when it is high
wr_en  in  1  write strobe, one clk cycle, sampled only when tick_en=1
wr_sel  in  2  0=load+start, 1=control, 2=clear flag, 3=stop
wr_chan  in  CH_W  target channel
wr_data  in  CNT_W  load value. For control writes: bit0=auto-reload, bit1=irq enable
rd_chan  in  CH_W  read channel select
rd_count  out  CNT_W  current counter of rd_chan (combinational mux)
tm  out  NCH  per-channel sticky TM flags
irq  out  1  OR over channels of (tm & irq_en), registered

Behaviour:
- Reset: all counters, reload registers, prescalers, mode and enable bits are 0. Every channel stops with run=0. tm=0, irq=0.
- Per channel state: IDLE (run=0) and RUN (run=1).
- Load (wr_sel=0), same tick_en cycle:
  - reload<=count<=wr_data, pre<=0, tm[ch]<=0, run<=1.
  - Load of value 0 is legal.
- In RUN, on each tick_en:
  - pre increments.
  - When pre==PRE_DIV-1: pre<=0 and count decrements.
  - If count==0 at that point, this is an underflow.
- Underflow:
  - tm[ch]<=1.
  - One-shot: run<=0. count wraps to all-ones and holds.
  - Auto-reload: count<=reload, run stays 1.
- Period from load to first tm: (N+1)*PRE_DIV tick_en pulses, N being the loaded value. Auto-reload repeats with the same period.
- Control write (wr_sel=1): updates mode and irq_en only. Does not disturb count, pre or run.
- Clear (wr_sel=2): tm[ch]<=0.
- Stop (wr_sel=3): run<=0. Count and pre are frozen. tm is untouched.
- Simultaneous events on the same channel:
  - Load and underflow: load wins, tm=0.
  - Clear and underflow: set wins, tm=1.
  - Stop and underflow: tm set, run=0.
- Writes to a channel index >= NCH are ignored.
- irq updates one clk after a tm or irq_en change, with no dependence on tick_en. Deasserts only via clear, load, or irq_en=0.
- tick_en low freezes everything except writes. Writes are also gated by tick_en.
- Reset asserted mid-count returns the channel to IDLE immediately (asynchronous).

Optional Feature:
UCOM_TIMER_CASCADE_EN. When defined, control bit2 (cascade) exists per channel for channels 1..NCH-1. In cascade mode the channel ignores its prescaler and decrements once per underflow of channel i-1, in the same cycle that underflow occurs. This forms a wider combined timer. When undefined, bit2 is ignored and every channel always uses its own prescaler.

Decomposition:
- Shared package ucom_timer_pkg holds:
  - wr_sel encodings (WS_LOAD, WS_CTRL, WS_CLR, WS_STOP)
  - control bit positions (CTL_RELOAD, CTL_IEN, CTL_CASC)
  - a channel-state struct {run, reload, irq_en, casc}
- One sub-module, ucom_timer_chan: a single channel containing prescaler, counter, mode and flag. It outputs an underflow pulse for cascading.
- The top level instantiates NCH channels and contains the write decode, the read mux and the irq OR/register.

Test Plan:
- Load ch0=3, PRE_DIV=64, one-shot, tick_en every cycle -> tm[0] rises after exactly 256 ticks; run=0; rd_count=all-ones and held.
- ch1 auto-reload, load 1, irq_en=1 -> tm[1] set at 128 ticks; irq=1 one clk later; clear at tick 130 -> tm reasserts at tick 256 and count reloads to 1.
- ch2 load 5, then stop after 100 ticks -> rd_count=4 held for 500 ticks; load 0 -> tm after 64 ticks.
- Clear coincident with underflow on ch3 -> tm=1; load coincident with underflow -> tm=0 and count equals the new value.
- Assert reset mid-count on all channels -> tm=0, irq=0, rd_count=0 asynchronously, and nothing runs afterwards until a load.
- With UCOM_TIMER_CASCADE_EN: ch0 auto-reload load 0, ch1 cascade load 2 -> tm[1] at 3*64=192 ticks; without the macro, the same stimulus gives tm[1] at 192 ticks from the prescaler, and bit2 has no effect (check with ch1 loaded 1 -> tm at 128).

Source files
------------

// File: rtl/ucom_timer_pkg.sv
// Shared definitions for the ucom_timer_array channel bank: write-select codes,
// control-word bit positions and the per-channel mode/run state record.
package ucom_timer_pkg;

  typedef enum logic [1:0] {
    WS_LOAD = 2'd0,
    WS_CTRL = 2'd1,
    WS_CLR  = 2'd2,
    WS_STOP = 2'd3
  } wr_sel_e;

  localparam int CTL_RELOAD = 0;
  localparam int CTL_IEN    = 1;
  localparam int CTL_CASC   = 2;

  // run=0 is IDLE, run=1 is RUN; the other fields are the channel's mode bits.
  typedef struct packed {
    logic run;
    logic reload;
    logic irq_en;
    logic casc;
  } chan_state_t;

endpackage

// File: rtl/ucom_timer_chan.sv
// One timer channel: prescaler, down counter, one-shot/auto-reload mode, sticky
// TM flag. Emits a single-cycle underflow pulse used to cascade the next channel.
module ucom_timer_chan
  import ucom_timer_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int PRE_DIV = 64,
  parameter bit CASC_OK = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             ld_i,
  input  logic             ctl_i,
  input  logic             clr_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             casc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tm_o,
  output logic             irq_en_o,
  output logic             uflow_o,
  output chan_state_t      state_o
);

  localparam int PRE_W = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tm_q, tm_d;
  logic             step, uflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= '0;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      tm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tm_q     <= tm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tm_d     = tm_q;
    step     = 1'b0;
    uflow    = 1'b0;

    if (tick_en && state_q.run) begin
      if (state_q.casc) begin
        step = casc_i;
      end else if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
      if (step) begin
        if (count_q == '0) begin
          uflow = 1'b1;
          tm_d  = 1'b1;
          if (state_q.reload) begin
            count_d = reload_q;
          end else begin
            count_d       = '1;
            state_d.run   = 1'b0;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    // A flag set by this cycle's underflow beats a coincident clear.
    if (clr_i && !uflow) tm_d = 1'b0;
    if (ctl_i) begin
      state_d.reload = data_i[CTL_RELOAD];
      state_d.irq_en = data_i[CTL_IEN];
      state_d.casc   = CASC_OK & data_i[CTL_CASC];
    end
    if (stop_i) state_d.run = 1'b0;
    if (ld_i) begin
      reload_d    = data_i;
      count_d     = data_i;
      pre_d       = '0;
      tm_d        = 1'b0;
      state_d.run = 1'b1;
    end
  end

  assign count_o  = count_q;
  assign tm_o     = tm_q;
  assign irq_en_o = state_q.irq_en;
  assign uflow_o  = uflow & ~ld_i;
  assign state_o  = state_q;

endmodule

// File: rtl/ucom_timer_array.sv
// NCH-channel timer bank: write decode, channel instances, read mux, registered irq.
// Define UCOM_TIMER_CASCADE_EN to let channels 1..NCH-1 count underflows of the channel below.
module ucom_timer_array
  import ucom_timer_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 6,
  parameter int PRE_DIV = 64,
  parameter int CH_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_en,
  input  logic                    wr_en,
  input  logic [1:0]              wr_sel,
  input  logic [CH_W-1:0]         wr_chan,
  input  logic [CNT_W-1:0]        wr_data,
  input  logic [CH_W-1:0]         rd_chan,
  output logic [CNT_W-1:0]        rd_count,
  output logic [NCH-1:0]          tm,
  output logic                    irq,
  output chan_state_t [NCH-1:0]   dbg_state
);

`ifdef UCOM_TIMER_CASCADE_EN
  localparam bit CASC_BUILD = 1'b1;
`else
  localparam bit CASC_BUILD = 1'b0;
`endif

  logic             wr_ok;
  logic [CNT_W-1:0] cnt     [NCH];
  logic             uflow   [NCH];
  logic             casc_in [NCH];
  logic [NCH-1:0]   ien;
  logic             irq_q;

  // Writes only land on a tick_en cycle and only for an existing channel.
  assign wr_ok = wr_en & tick_en & (int'(wr_chan) < NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = wr_ok && (int'(wr_chan) == i);

    if (i == 0) begin : g_head
      assign casc_in[i] = 1'b0;
    end else begin : g_link
      assign casc_in[i] = uflow[i-1];
    end

    ucom_timer_chan #(
      .CNT_W   (CNT_W),
      .PRE_DIV (PRE_DIV),
      .CASC_OK (CASC_BUILD && (i > 0))
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .tick_en  (tick_en),
      .ld_i     (sel && (wr_sel == WS_LOAD)),
      .ctl_i    (sel && (wr_sel == WS_CTRL)),
      .clr_i    (sel && (wr_sel == WS_CLR)),
      .stop_i   (sel && (wr_sel == WS_STOP)),
      .data_i   (wr_data),
      .casc_i   (casc_in[i]),
      .count_o  (cnt[i]),
      .tm_o     (tm[i]),
      .irq_en_o (ien[i]),
      .uflow_o  (uflow[i]),
      .state_o  (dbg_state[i])
    );
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(rd_chan) == i) rd_count = cnt[i];
    end
  end

  // irq follows tm/irq_en every clk, independent of tick_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= |(tm & ien);
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_ucom_timer_array.sv
// Bench for ucom_timer_array: directed scenarios plus random traffic, all checked
// against a remaining-ticks model of each channel.
module tb_ucom_timer_array;
  import ucom_timer_pkg::*;

  localparam int NCH     = 4;
  localparam int CNT_W   = 6;
  localparam int PRE_DIV = 64;
  localparam int CH_W    = 2;
  localparam int ONES    = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  tick_en;
  logic                  wr_en;
  logic [1:0]            wr_sel;
  logic [CH_W-1:0]       wr_chan;
  logic [CNT_W-1:0]      wr_data;
  logic [CH_W-1:0]       rd_chan;
  logic [CNT_W-1:0]      rd_count;
  logic [NCH-1:0]        tm;
  logic                  irq;
  chan_state_t [NCH-1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit model_chk = 1'b1;

  // Model: a running channel is described by ticks left until its next underflow.
  bit             m_run    [NCH];
  bit             m_auto   [NCH];
  int             m_rem    [NCH];
  int             m_reload [NCH];
  int             m_held   [NCH];
  logic [NCH-1:0] m_tm;
  logic [NCH-1:0] m_ien;
  logic           m_irq;

  ucom_timer_array #(
    .NCH(NCH), .CNT_W(CNT_W), .PRE_DIV(PRE_DIV), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_chan(wr_chan), .wr_data(wr_data), .rd_chan(rd_chan), .rd_count(rd_count),
    .tm(tm), .irq(irq), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int disp(input int ch);
    if (m_run[ch]) return (m_rem[ch] - 1) / PRE_DIV;
    return m_held[ch];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_auto[c] = 0; m_rem[c] = 0; m_reload[c] = 0; m_held[c] = 0;
    end
    m_tm = '0; m_ien = '0; m_irq = 1'b0;
  endtask

  // Predicts the effect of the coming clock edge with the current inputs.
  task automatic model_apply();
    bit uf [NCH];
    int ch;
    m_irq = |(m_tm & m_ien);
    for (int c = 0; c < NCH; c++) begin
      uf[c] = 0;
      if (tick_en && m_run[c]) begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin
          uf[c] = 1;
          m_tm[c] = 1'b1;
          if (m_auto[c]) m_rem[c] = (m_reload[c] + 1) * PRE_DIV;
          else begin m_run[c] = 0; m_held[c] = ONES; end
        end
      end
    end
    ch = int'(wr_chan);
    if (tick_en && wr_en && ch < NCH) begin
      case (wr_sel)
        2'd0: begin
          m_reload[ch] = int'(wr_data);
          m_rem[ch] = (int'(wr_data) + 1) * PRE_DIV;
          m_run[ch] = 1; m_tm[ch] = 1'b0;
        end
        2'd1: begin m_auto[ch] = wr_data[0]; m_ien[ch] = wr_data[1]; end
        2'd2: if (!uf[ch]) m_tm[ch] = 1'b0;
        default: if (m_run[ch]) begin m_held[ch] = disp(ch); m_run[ch] = 0; end
      endcase
    end
  endtask

  task automatic clk_step();
    rd_chan = CH_W'($urandom_range(0, NCH - 1));
    model_apply();
    @(posedge clk);
    #1;
    if (model_chk) begin
      check("tm", 32'(tm), 32'(m_tm));
      check("irq", 32'(irq), 32'(m_irq));
      check("rd_count", 32'(rd_count), 32'(disp(int'(rd_chan))));
    end
  endtask

  task automatic write(input logic [1:0] sel, input int ch, input int data);
    tick_en = 1'b1; wr_en = 1'b1;
    wr_sel = sel; wr_chan = CH_W'(ch); wr_data = CNT_W'(data);
    clk_step();
    wr_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick_en = 1'b1;
    repeat (n) clk_step();
  endtask

  task automatic peek_count(input string tag, input int ch, input int exp);
    rd_chan = CH_W'(ch);
    #1;
    check(tag, 32'(rd_count), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; tick_en = 1'b0; wr_en = 1'b0; wr_sel = '0;
    wr_chan = '0; wr_data = '0; rd_chan = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      peek_count("reset_count", c, 0);
      check("reset_run", 32'(dbg_state[c].run), 0);
    end
    check("reset_tm", 32'(tm), 0);
    check("reset_irq", 32'(irq), 0);
    @(negedge clk) reset = 1'b1;

    // One-shot ch0 loaded with 3: flag after exactly 256 ticks, then all-ones held.
    write(WS_CTRL, 0, 0);
    write(WS_LOAD, 0, 3);
    ticks(255); check("os_tm_early", 32'(tm[0]), 0);
    ticks(1);   check("os_tm_at_256", 32'(tm[0]), 1);
    check("os_run", 32'(dbg_state[0].run), 0);
    peek_count("os_ones", 0, ONES);
    ticks(20);  peek_count("os_ones_held", 0, ONES);

    // Auto-reload ch1 with irq: flag at 128, irq one clk later, clear, flag again at 256.
    write(WS_CTRL, 1, 3);
    write(WS_LOAD, 1, 1);
    ticks(127); check("ar_tm_early", 32'(tm[1]), 0);
    ticks(1);   check("ar_tm_128", 32'(tm[1]), 1); check("ar_irq_lag", 32'(irq), 0);
    ticks(1);   check("ar_irq_129", 32'(irq), 1);
    write(WS_CLR, 1, 0);
    check("ar_clr_tm", 32'(tm[1]), 0); check("ar_irq_130", 32'(irq), 1);
    ticks(1);   check("ar_irq_131", 32'(irq), 0);
    ticks(124); check("ar_tm_255", 32'(tm[1]), 0);
    ticks(1);   check("ar_tm_256", 32'(tm[1]), 1);
    peek_count("ar_reload", 1, 1);

    // Stop ch2 mid-count, then a load of 0 fires after one prescaler period.
    write(WS_LOAD, 2, 5);
    ticks(100);
    write(WS_STOP, 2, 0);
    peek_count("stop_count", 2, 4);
    ticks(500);
    peek_count("stop_held", 2, 4);
    check("stop_run", 32'(dbg_state[2].run), 0);
    write(WS_LOAD, 2, 0);
    ticks(63);  check("z_tm_early", 32'(tm[2]), 0);
    ticks(1);   check("z_tm_64", 32'(tm[2]), 1);

    // Coincident clear/load with an underflow on ch3.
    write(WS_CTRL, 3, 1);
    write(WS_LOAD, 3, 0);
    ticks(63);
    write(WS_CLR, 3, 0);
    check("clr_vs_uf", 32'(tm[3]), 1);
    ticks(63);
    write(WS_LOAD, 3, 9);
    check("load_vs_uf", 32'(tm[3]), 0);
    peek_count("load_vs_uf_cnt", 3, 9);

    // Random traffic against the model, including writes with tick_en low.
    for (int i = 0; i < 4000; i++) begin
      tick_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        wr_en = 1'b1;
        wr_sel = 2'($urandom_range(0, 3));
        wr_chan = CH_W'($urandom_range(0, NCH - 1));
        wr_data = (wr_sel == 2'd0) ? CNT_W'($urandom_range(0, 3)) : CNT_W'($urandom_range(0, 3));
      end
      clk_step();
      wr_en = 1'b0;
    end

    // Asynchronous reset in the middle of counting with tm and irq raised.
    write(WS_CTRL, 0, 2);
    write(WS_LOAD, 0, 0);
    for (int c = 1; c < NCH; c++) write(WS_LOAD, c, 7);
    ticks(64);
    check("pre_rst_irq", 32'(irq), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("arst_tm", 32'(tm), 0);
    check("arst_irq", 32'(irq), 0);
    for (int c = 0; c < NCH; c++) peek_count("arst_count", c, 0);
    @(negedge clk) reset = 1'b1;
    ticks(200);
    check("post_rst_tm", 32'(tm), 0);
    for (int c = 0; c < NCH; c++) check("post_rst_run", 32'(dbg_state[c].run), 0);

`ifdef UCOM_TIMER_CASCADE_EN
    // Cascade: ch1 counts ch0 underflows, 3 of them for a load of 2.
    model_chk = 1'b0;
    write(WS_CTRL, 0, 1);
    write(WS_CTRL, 1, 4);
    write(WS_LOAD, 1, 2);
    write(WS_LOAD, 0, 0);
    ticks(191); check("casc_tm_early", 32'(tm[1]), 0);
    ticks(1);   check("casc_tm_192", 32'(tm[1]), 1);
`else
    // Without cascade support, bit2 is ignored and ch1 runs from its own prescaler.
    write(WS_CTRL, 0, 1);
    write(WS_LOAD, 0, 0);
    write(WS_CTRL, 1, 4);
    write(WS_LOAD, 1, 2);
    ticks(191); check("nocasc_tm_early", 32'(tm[1]), 0);
    ticks(1);   check("nocasc_tm_192", 32'(tm[1]), 1);
    write(WS_LOAD, 1, 1);
    ticks(127); check("nocasc_b2_early", 32'(tm[1]), 0);
    ticks(1);   check("nocasc_b2_128", 32'(tm[1]), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
